// File: rtl/uart_tx_frame_ctrl.sv
// uart_tx_frame_ctrl: UART transmit frame sequencer with valid/ready input and self-timed bit periods
module uart_tx_frame_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_BIT = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  tx_data,
  output logic                  busy,
  output logic                  done
);
  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int BW  = $clog2(CPB);
  localparam int NW  = $clog2(DATA_WIDTH + 1);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  logic [2:0]            state;
  logic [BW-1:0]         baud;
  logic [NW-1:0]         bitc;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par;
  logic                  bit_end;
  assign bit_end = baud == BW'(CPB - 1);
  // baud counter sits at zero in IDLE so bit edges align to the accepting edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      baud       <= '0;
      bitc       <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      tx_data    <= 1'b1;
      data_ready <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      baud <= (state == IDLE || bit_end) ? '0 : baud + BW'(1);
      case (state)
        IDLE: if (data_valid && data_ready) begin
          state      <= START;
          tx_data    <= 1'b0;
          data_ready <= 1'b0;
          busy       <= 1'b1;
          shreg      <= data_in;
          par        <= (^data_in) ^ (PARITY_ODD != 0);
        end
        START: if (bit_end) begin
          state   <= DATA;
          tx_data <= shreg[0];
          shreg   <= shreg >> 1;
          bitc    <= '0;
        end
        DATA: if (bit_end) begin
          if (bitc == NW'(DATA_WIDTH - 1)) begin
            state   <= (PARITY_BIT != 0) ? PARITY : STOP;
            tx_data <= (PARITY_BIT != 0) ? par : 1'b1;
            bitc    <= '0;
          end else begin
            bitc    <= bitc + NW'(1);
            tx_data <= shreg[0];
            shreg   <= shreg >> 1;
          end
        end
        PARITY: if (bit_end) begin
          state   <= STOP;
          tx_data <= 1'b1;
        end
        STOP: if (bit_end) begin
          if (bitc == NW'(STOP_BITS - 1)) begin
            state      <= IDLE;
            data_ready <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b1;
          end else begin
            bitc <= bitc + NW'(1);
          end
        end
        default: begin
          state      <= IDLE;
          tx_data    <= 1'b1;
          data_ready <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// tb_uart_tx_frame_ctrl: three configurations (even parity, odd parity, no parity/2 stops) at 16 clocks per bit
module tb_uart_tx_frame_ctrl;
  localparam int CPB = 16;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic [2:0] valid = 3'b000;
  logic [2:0] ready, tx, busy, done;
  int checks = 0;
  int errors = 0;
  int rst_cnt = 0;
  typedef struct {int k; logic [7:0] d;} exp_t;
  typedef struct {int k; logic [7:0] d; logic tog; logic par;} vec_t;
  exp_t sb_q[$];

  function automatic bit pb(int k); return k != 2; endfunction
  function automatic bit po(int k); return k == 1; endfunction
  function automatic int sb(int k); return k == 2 ? 2 : 1; endfunction

  always #5 clk = ~clk;
  always @(posedge clk) if (rst) rst_cnt++;

  for (genvar g = 0; g < 3; g++) begin : dut
    uart_tx_frame_ctrl #(
      .DATA_WIDTH(8), .PARITY_BIT(g == 2 ? 0 : 1), .PARITY_ODD(g == 1 ? 1 : 0),
      .STOP_BITS(g == 2 ? 2 : 1), .CLK_FREQ(16), .BAUD_RATE(1)
    ) u (
      .clk(clk), .rst(rst), .data_in(data_in), .data_valid(valid[g]),
      .data_ready(ready[g]), .tx_data(tx[g]), .busy(busy[g]), .done(done[g])
    );
    // line monitor: decodes each frame mid-bit and pops the scoreboard
    initial begin : mon
      logic [7:0] d;
      logic p, s, st;
      int r0;
      exp_t e;
      forever begin
        @(negedge tx[g]);
        r0 = rst_cnt;
        repeat (8) @(negedge clk);
        st = tx[g];
        for (int i = 0; i < 8; i++) begin repeat (CPB) @(negedge clk); d[i] = tx[g]; end
        p = 1'b0;
        if (pb(g)) begin repeat (CPB) @(negedge clk); p = tx[g]; end
        s = 1'b1;
        for (int i = 0; i < sb(g); i++) begin repeat (CPB) @(negedge clk); s &= tx[g]; end
        if (rst_cnt == r0) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_empty inst %0d got data %02h with nothing expected", g, d);
          end else begin
            e = sb_q.pop_front();
            if (e.k != g || e.d != d || st !== 1'b0 || s !== 1'b1 || (pb(g) && p !== ((^e.d) ^ po(g)))) begin
              errors++;
              $display("FAIL sb inst %0d got data %02h par %b start %b stop %b, required inst %0d data %02h par %b start 0 stop 1",
                       g, d, p, st, s, e.k, e.d, (^e.d) ^ po(g));
            end
          end
        end
      end
    end
  end

  task automatic wait_ready(input int k, output bit ok);
    int n = 0;
    @(negedge clk);
    while (!ready[k] && n < 400) begin @(negedge clk); n++; end
    ok = ready[k];
    checks++;
    if (!ok) begin errors++; $display("FAIL ready_wait inst %0d ready %b required 1", k, ready[k]); end
  endtask

  task automatic send(input int k, input logic [7:0] d, input logic tog, input logic exp_par);
    bit ok;
    int f, nb, nd, dc, lc, rc;
    logic ex, pv, lv, le;
    f = CPB * (9 + pb(k) + sb(k));
    wait_ready(k, ok);
    if (!ok) return;
    data_in = d;
    valid[k] = 1'b1;
    sb_q.push_back('{k, d});
    @(posedge clk);
    #1 valid[k] = 1'b0;
    nb = 0; nd = 0; dc = 0; lc = 0; rc = 0; pv = 1'b0; lv = 1'b0; le = 1'b0;
    for (int c = 1; c <= f + 1; c++) begin
      @(negedge clk);
      if (tog) data_in = ~data_in;
      ex = (c <= CPB) ? 1'b0 : (c <= CPB * 9) ? d[(c - CPB - 1) / CPB] :
           (pb(k) && c <= CPB * 10) ? ((^d) ^ po(k)) : 1'b1;
      if (tx[k] !== ex && lc == 0) begin lc = c; lv = tx[k]; le = ex; end
      if (c == CPB * 9 + 8) pv = tx[k];
      if (busy[k] === 1'b1 && c <= f) nb++;
      if (busy[k] !== 1'b0 && c > f) nb += 1000;
      if (done[k] !== 1'b0) begin nd++; dc = c; end
      if (ready[k] !== (c == f + 1) && rc == 0) rc = c;
    end
    checks += 4;
    if (lc != 0) begin errors++; $display("FAIL line inst %0d data %02h cycle %0d tx %b required %b", k, d, lc, lv, le); end
    if (nb != f) begin errors++; $display("FAIL busy inst %0d data %02h busy count %0d required %0d", k, d, nb, f); end
    if (nd != 1 || dc != f + 1) begin errors++; $display("FAIL done inst %0d data %02h pulses %0d at cycle %0d required 1 at %0d", k, d, nd, dc, f + 1); end
    if (rc != 0) begin errors++; $display("FAIL ready inst %0d data %02h wrong at cycle %0d value %b", k, d, rc, ready[k]); end
    if (pb(k)) begin
      checks++;
      if (pv !== exp_par) begin errors++; $display("FAIL parity inst %0d data %02h slot %b required %b", k, d, pv, exp_par); end
    end
  endtask

  initial begin
    vec_t tbl[6];
    bit ok;
    logic t176, t177, t178, r177, d177, got;
    int rb, n;
    tbl = '{'{0, 8'hA5, 1'b0, 1'b0}, '{1, 8'h01, 1'b0, 1'b0}, '{0, 8'h01, 1'b0, 1'b1},
            '{2, 8'h3C, 1'b1, 1'b0}, '{1, 8'hFF, 1'b0, 1'b1}, '{2, 8'h96, 1'b1, 1'b0}};
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks += 4;
      if (tx[k] !== 1'b1) begin errors++; $display("FAIL rst_tx inst %0d got %b required 1", k, tx[k]); end
      if (ready[k] !== 1'b1) begin errors++; $display("FAIL rst_ready inst %0d got %b required 1", k, ready[k]); end
      if (busy[k] !== 1'b0) begin errors++; $display("FAIL rst_busy inst %0d got %b required 0", k, busy[k]); end
      if (done[k] !== 1'b0) begin errors++; $display("FAIL rst_done inst %0d got %b required 0", k, done[k]); end
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) send(tbl[i].k, tbl[i].d, tbl[i].tog, tbl[i].par);
    // back-to-back with valid held high; data_in changes mid-frame
    wait_ready(0, ok);
    data_in = 8'h00;
    valid[0] = 1'b1;
    sb_q.push_back('{0, 8'h00});
    sb_q.push_back('{0, 8'hFF});
    @(posedge clk);
    rb = 0; t176 = 1'b0; t177 = 1'b0; t178 = 1'b1; r177 = 1'b0; d177 = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 5) data_in = 8'hFF;
      if (c == 176) t176 = tx[0];
      if (c == 177) begin t177 = tx[0]; r177 = ready[0]; d177 = done[0]; end
      if (c == 178) begin t178 = tx[0]; valid[0] = 1'b0; end
      if (c != 177 && ready[0] !== 1'b0) rb++;
    end
    checks += 6;
    if (t176 !== 1'b1) begin errors++; $display("FAIL b2b_stop tx %b required 1", t176); end
    if (t177 !== 1'b1) begin errors++; $display("FAIL b2b_idle tx %b required 1", t177); end
    if (t178 !== 1'b0) begin errors++; $display("FAIL b2b_start tx %b required 0", t178); end
    if (r177 !== 1'b1) begin errors++; $display("FAIL b2b_ready ready %b required 1", r177); end
    if (d177 !== 1'b1) begin errors++; $display("FAIL b2b_done done %b required 1", d177); end
    if (rb != 0) begin errors++; $display("FAIL b2b_ready_low ready high %0d cycles required 0", rb); end
    got = 1'b0;
    for (n = 0; n < 300 && !got; n++) begin @(negedge clk); got = done[0]; end
    checks++;
    if (!got) begin errors++; $display("FAIL b2b_second_done done %b required 1", got); end
    // reset during data bit 3; this word is dropped so it is not pushed
    wait_ready(0, ok);
    data_in = 8'h5A;
    valid[0] = 1'b1;
    @(posedge clk);
    #1 valid[0] = 1'b0;
    for (int c = 1; c <= 70; c++) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks += 4;
    if (tx[0] !== 1'b1) begin errors++; $display("FAIL midrst_tx got %b required 1", tx[0]); end
    if (ready[0] !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b required 1", ready[0]); end
    if (busy[0] !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b required 0", busy[0]); end
    if (done[0] !== 1'b0) begin errors++; $display("FAIL midrst_done got %b required 0", done[0]); end
    got = 1'b0;
    for (int c = 0; c < 200; c++) begin @(negedge clk); got |= done[0]; end
    checks++;
    if (got !== 1'b0) begin errors++; $display("FAIL midrst_no_done done %b required 0", got); end
    send(0, 8'hC3, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL sb_leftover %0d entries required 0", sb_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
